// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package : cpu_pkg
// Purpose : Shared CPU-core types and constants for the writeback path:
//           register-file geometry, the writeback request record and a
//           one-hot helper used for pending-register masks.
// Revision: 1.0  initial release
// ============================================================================
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd_idx;
    logic [XLEN-1:0]      rd_data;
  } wb_req_t;

  // One-hot register mask for a destination index.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Purpose : Small FIFO of buffered LSU writeback requests. Pointers carry an
//           extra wrap bit so full and empty are distinguished without a
//           separate flag. Per-entry destination indices and valid bits are
//           exported so the stage can build its pending-register mask.
// Ports   : clk, rstn (async, active-low)
//           push/push_data  - enqueue one request
//           pop             - dequeue the head request
//           head            - current head request (valid when !empty)
//           empty/full      - occupancy flags, from registered pointers only
//           entry_valid     - per-slot occupancy
//           entry_rd_idx    - per-slot destination register
// Revision: 1.0  initial release
// ============================================================================
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               push,
  input  wb_req_t                            push_data,
  input  logic                               pop,
  output wb_req_t                            head,
  output logic                               empty,
  output logic                               full,
  output logic [DEPTH-1:0]                   entry_valid,
  output logic [DEPTH-1:0][REG_IDX_W-1:0]    entry_rd_idx
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [PW:0]   wptr;
  logic [PW:0]   rptr;
  logic [PW:0]   count;

  assign count = wptr - rptr;
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));
  assign head  = mem[rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  // Storage needs no reset: occupancy is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-1:0]] <= push_data;
  end

  // A slot is occupied when its distance from the read pointer (mod DEPTH)
  // is below the current count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PW-1:0] off;
    assign off             = PW'(i) - rptr[PW-1:0];
    assign entry_valid[i]  = ({1'b0, off} < count);
    assign entry_rd_idx[i] = mem[i].rd_idx;
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : wb_stage
// Purpose : Writeback stage driving the register file's single write port.
//           Execute results (no backpressure) always win the port; LSU
//           results are buffered in wb_fifo while execute holds it, and
//           bypass straight to the output registers when the FIFO is empty.
//           A pending mask flags registers with LSU writes still in flight.
// Ports   : clk, rstn (async, active-low)
//           ex_valid/ex_rd_en/ex_rd_idx/ex_rd_data   - execute result
//           lsu_valid/lsu_ready/lsu_rd_idx/lsu_rd_data - LSU result handshake
//           wb_rd_en/wb_rd_idx/wb_rd_data            - registered RF write
//           pending_mask                             - in-flight LSU rds
//           wb_count                                 - committed write count
// Revision: 1.0  initial release
// ============================================================================
module wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 ex_valid,
  input  logic                 ex_rd_en,
  input  logic [4:0]           ex_rd_idx,
  input  logic [XLEN-1:0]      ex_rd_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [4:0]           lsu_rd_idx,
  input  logic [XLEN-1:0]      lsu_rd_data,
  output logic                 wb_rd_en,
  output logic [4:0]           wb_rd_idx,
  output logic [XLEN-1:0]      wb_rd_data,
  output logic [31:0]          pending_mask,
  output logic [31:0]          wb_count
);

  // The request record is fixed by the package; refuse mismatched builds.
  if (XLEN != cpu_pkg::XLEN) begin : g_xlen_check
    $error("wb_stage: XLEN must equal cpu_pkg::XLEN");
  end

  logic                                 fifo_empty;
  logic                                 fifo_full;
  wb_req_t                              fifo_head;
  logic [LQ_DEPTH-1:0]                  fifo_valid;
  logic [LQ_DEPTH-1:0][REG_IDX_W-1:0]   fifo_rd_idx;

  logic    ex_wr;
  logic    lsu_keep;
  logic    push;
  logic    pop;
  logic    sel;
  logic    sel_lsu;
  wb_req_t sel_req;
  wb_req_t lsu_req;
  logic    wb_from_lsu;

  // Ready depends only on registered FIFO state, so it never combinationally
  // follows lsu_valid or the execute inputs.
  assign lsu_ready = !fifo_full;

  assign ex_wr    = ex_valid & ex_rd_en & (ex_rd_idx != 5'd0);
  // x0 transfers complete the handshake but are dropped here.
  assign lsu_keep = lsu_valid & lsu_ready & (lsu_rd_idx != 5'd0);

  assign lsu_req.rd_idx  = lsu_rd_idx;
  assign lsu_req.rd_data = lsu_rd_data;

  always_comb begin
    sel             = 1'b0;
    sel_lsu         = 1'b0;
    push            = 1'b0;
    pop             = 1'b0;
    sel_req.rd_idx  = ex_rd_idx;
    sel_req.rd_data = ex_rd_data;
    if (ex_wr) begin
      sel  = 1'b1;
      push = lsu_keep;
    end else if (!fifo_empty) begin
      // Drain the oldest buffered entry first; a new transfer queues behind it.
      sel     = 1'b1;
      sel_lsu = 1'b1;
      pop     = 1'b1;
      push    = lsu_keep;
      sel_req = fifo_head;
    end else if (lsu_keep) begin
      sel     = 1'b1;
      sel_lsu = 1'b1;
      sel_req = lsu_req;
    end
  end

  wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rstn         (rstn),
    .push         (push),
    .push_data    (lsu_req),
    .pop          (pop),
    .head         (fifo_head),
    .empty        (fifo_empty),
    .full         (fifo_full),
    .entry_valid  (fifo_valid),
    .entry_rd_idx (fifo_rd_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_rd_en    <= 1'b0;
      wb_rd_idx   <= '0;
      wb_rd_data  <= '0;
      wb_from_lsu <= 1'b0;
      wb_count    <= '0;
    end else begin
      wb_rd_en    <= sel;
      wb_from_lsu <= sel_lsu;
      if (sel) begin
        wb_rd_idx  <= sel_req.rd_idx;
        wb_rd_data <= sel_req.rd_data;
        wb_count   <= wb_count + 32'd1;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (fifo_valid[i]) pending_mask = pending_mask | rd_onehot(fifo_rd_idx[i]);
    end
    if (wb_rd_en && wb_from_lsu) pending_mask = pending_mask | rd_onehot(wb_rd_idx);
    pending_mask[0] = 1'b0;
  end

`ifndef SYNTHESIS
  // Execute must not overtake an in-flight LSU write to the same register.
  always @(posedge clk) begin
    if (rstn && ex_wr) begin
      assert (!pending_mask[ex_rd_idx])
        else $error("wb_stage: execute write to pending rd x%0d", ex_rd_idx);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_stage
// Purpose : Self-checking bench for wb_stage. A queue-based reference model
//           tracks buffered LSU results and the expected register-file write
//           stream; directed scenarios and randomized traffic compare the
//           DUT against it cycle by cycle.
// Revision: 1.0  initial release
// ============================================================================
module tb_wb_stage;
  import cpu_pkg::*;

  localparam int LQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid, ex_rd_en, lsu_valid;
  logic [4:0]  ex_rd_idx, lsu_rd_idx;
  logic [31:0] ex_rd_data, lsu_rd_data;
  logic        lsu_ready, wb_rd_en;
  logic [4:0]  wb_rd_idx;
  logic [31:0] wb_rd_data, pending_mask, wb_count;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .ex_valid(ex_valid), .ex_rd_en(ex_rd_en), .ex_rd_idx(ex_rd_idx), .ex_rd_data(ex_rd_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd_idx(lsu_rd_idx), .lsu_rd_data(lsu_rd_data),
    .wb_rd_en(wb_rd_en), .wb_rd_idx(wb_rd_idx), .wb_rd_data(wb_rd_data),
    .pending_mask(pending_mask), .wb_count(wb_count)
  );

  typedef struct { logic [4:0] idx; logic [31:0] data; } ent_t;

  ent_t        q[$];
  logic        exp_en, exp_src_lsu;
  logic [4:0]  exp_idx;
  logic [31:0] exp_data, exp_count;
  logic        exp_ready, obs_ready;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) m[q[i].idx] = 1'b1;
    if (exp_en && exp_src_lsu) m[exp_idx] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_en = 0; exp_src_lsu = 0; exp_idx = '0; exp_data = '0; exp_count = '0;
  endtask

  // Drive one cycle of inputs, advance the reference model, and return #1
  // after the rising edge with expectations updated.
  task automatic tick(input logic xv, input logic xe, input logic [4:0] xi, input logic [31:0] xd,
                      input logic lv, input logic [4:0] li, input logic [31:0] ld);
    logic ex_w, acc, wr, src;
    logic [4:0] ni;
    logic [31:0] nd;
    ent_t e;
    ex_valid = xv; ex_rd_en = xe; ex_rd_idx = xi; ex_rd_data = xd;
    lsu_valid = lv; lsu_rd_idx = li; lsu_rd_data = ld;
    #1;
    obs_ready = lsu_ready;
    exp_ready = (q.size() < LQ_DEPTH);
    ex_w = xv && xe && (xi != 5'd0);
    acc  = lv && exp_ready && (li != 5'd0);
    wr = 0; src = 0; ni = exp_idx; nd = exp_data;
    if (ex_w) begin
      wr = 1; ni = xi; nd = xd;
      if (acc) q.push_back('{li, ld});
    end else if (q.size() != 0) begin
      e = q.pop_front();
      wr = 1; src = 1; ni = e.idx; nd = e.data;
      if (acc) q.push_back('{li, ld});
    end else if (acc) begin
      wr = 1; src = 1; ni = li; nd = ld;
    end
    @(posedge clk); #1;
    exp_en = wr; exp_src_lsu = src; exp_idx = ni; exp_data = nd;
    if (wr) exp_count = exp_count + 32'd1;
    ex_valid = 0; ex_rd_en = 0; lsu_valid = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    ex_valid = 0; ex_rd_en = 0; ex_rd_idx = 0; ex_rd_data = 0;
    lsu_valid = 0; lsu_rd_idx = 0; lsu_rd_data = 0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (wb_rd_en !== 1'b0 || wb_count !== 32'd0 || pending_mask !== 32'd0)
      begin n_errors++; $display("FAIL reset_state: en=%b count=%h mask=%h want 0", wb_rd_en, wb_count, pending_mask); end
    rstn = 1;
    #1;
    n_checks++; if (lsu_ready !== 1'b1)
      begin n_errors++; $display("FAIL reset_ready: got %b want 1", lsu_ready); end
    // Mid-traffic reset: fill the FIFO, then drop everything.
    tick(1, 1, 5'd2, 32'h22, 1, 5'd8, 32'h88);
    tick(1, 1, 5'd3, 32'h33, 1, 5'd9, 32'h99);
    #1 rstn = 0;
    #1;
    n_checks++; if (wb_rd_en !== 1'b0 || wb_rd_idx !== 5'd0 || wb_rd_data !== 32'd0)
      begin n_errors++; $display("FAIL midreset_wb: en=%b idx=%0d data=%h want 0/0/0", wb_rd_en, wb_rd_idx, wb_rd_data); end
    n_checks++; if (wb_count !== 32'd0 || pending_mask !== 32'd0 || lsu_ready !== 1'b1)
      begin n_errors++; $display("FAIL midreset_state: count=%h mask=%h ready=%b want 0/0/1", wb_count, pending_mask, lsu_ready); end
    model_reset();
    @(negedge clk);
    rstn = 1;
    tick(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (obs_ready !== 1'b1)
      begin n_errors++; $display("FAIL postreset_ready: got %b want 1", obs_ready); end
    n_checks++; if (wb_rd_en !== 1'b0 || pending_mask !== 32'd0)
      begin n_errors++; $display("FAIL postreset_nowrite: en=%b mask=%h want 0/0", wb_rd_en, pending_mask); end
  endtask

  task automatic test_execute();
    tick(1, 1, 5'd5, 32'h1234, 0, 0, 0);
    n_checks++; if (wb_rd_en !== 1'b1 || wb_rd_idx !== 5'd5 || wb_rd_data !== 32'h1234)
      begin n_errors++; $display("FAIL exec_write: en=%b idx=%0d data=%h want 1/5/1234", wb_rd_en, wb_rd_idx, wb_rd_data); end
    n_checks++; if (wb_count !== 32'd1 || pending_mask !== 32'd0)
      begin n_errors++; $display("FAIL exec_count: count=%0d mask=%h want 1/0", wb_count, pending_mask); end
    tick(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (wb_rd_en !== 1'b0 || wb_rd_idx !== 5'd5 || wb_rd_data !== 32'h1234)
      begin n_errors++; $display("FAIL exec_pulse_hold: en=%b idx=%0d data=%h want 0/5/1234", wb_rd_en, wb_rd_idx, wb_rd_data); end
  endtask

  task automatic test_bypass();
    tick(0, 0, 0, 0, 1, 5'd7, 32'hDEAD);
    n_checks++; if (wb_rd_en !== 1'b1 || wb_rd_idx !== 5'd7 || wb_rd_data !== 32'hDEAD)
      begin n_errors++; $display("FAIL bypass_write: en=%b idx=%0d data=%h want 1/7/dead", wb_rd_en, wb_rd_idx, wb_rd_data); end
    n_checks++; if (pending_mask !== 32'h80)
      begin n_errors++; $display("FAIL bypass_mask: got %h want 00000080", pending_mask); end
    tick(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (pending_mask !== 32'h0 || wb_rd_en !== 1'b0)
      begin n_errors++; $display("FAIL bypass_clear: mask=%h en=%b want 0/0", pending_mask, wb_rd_en); end
  endtask

  task automatic test_contention();
    logic [4:0]  offers [3]    = '{5'd3, 5'd4, 5'd6};
    logic        rdy_tbl [8]   = '{1, 1, 0, 0, 0, 1, 1, 1};
    logic [4:0]  idx_tbl [8]   = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd3, 5'd4, 5'd6, 5'd6};
    logic        en_tbl [8]    = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [31:0] mask_tbl [8]  = '{32'h08, 32'h18, 32'h18, 32'h18, 32'h18, 32'h50, 32'h40, 32'h00};
    int k = 0;
    for (int c = 0; c < 8; c++) begin
      logic xv, lv;
      logic [4:0] li;
      xv = (c < 4);
      lv = (k < 3);
      li = lv ? offers[k] : 5'd0;
      tick(xv, xv, 5'(10 + c), 32'hE00 + c, lv, li, 32'h100 + li);
      if (lv && obs_ready) k++;
      n_checks++; if (obs_ready !== rdy_tbl[c])
        begin n_errors++; $display("FAIL contend_ready[%0d]: got %b want %b", c, obs_ready, rdy_tbl[c]); end
      n_checks++; if (wb_rd_en !== en_tbl[c] || (en_tbl[c] && wb_rd_idx !== idx_tbl[c]))
        begin n_errors++; $display("FAIL contend_wb[%0d]: en=%b idx=%0d want %b/%0d", c, wb_rd_en, wb_rd_idx, en_tbl[c], idx_tbl[c]); end
      n_checks++; if (pending_mask !== mask_tbl[c])
        begin n_errors++; $display("FAIL contend_mask[%0d]: got %h want %h", c, pending_mask, mask_tbl[c]); end
      n_checks++; if (wb_rd_data !== exp_data)
        begin n_errors++; $display("FAIL contend_data[%0d]: got %h want %h", c, wb_rd_data, exp_data); end
    end
  endtask

  task automatic test_x0();
    tick(1, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF);
    n_checks++; if (obs_ready !== 1'b1)
      begin n_errors++; $display("FAIL x0_ready: got %b want 1", obs_ready); end
    n_checks++; if (wb_rd_en !== 1'b0 || wb_count !== exp_count || pending_mask !== 32'd0)
      begin n_errors++; $display("FAIL x0_filter: en=%b count=%0d mask=%h want 0/%0d/0", wb_rd_en, wb_count, pending_mask, exp_count); end
    tick(0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (wb_rd_en !== 1'b0)
      begin n_errors++; $display("FAIL x0_not_queued: en=%b want 0", wb_rd_en); end
  endtask

  task automatic test_wrap();
    force dut.wb_count = 32'hFFFF_FFFF;
    #1 release dut.wb_count;
    exp_count = 32'hFFFF_FFFF;
    tick(1, 1, 5'd9, 32'h9, 1, 5'd1, 32'h1001);
    n_checks++; if (wb_count !== 32'd0)
      begin n_errors++; $display("FAIL count_wrap: got %h want 00000000", wb_count); end
    // Each cycle pops the head and pushes a new entry, walking the pointers round.
    for (int i = 0; i < 11; i++) begin
      logic lv;
      lv = (i < 10);
      tick(0, 0, 0, 0, lv, 5'(i + 2), 32'h1000 + i + 2);
      n_checks++; if (wb_rd_en !== 1'b1 || wb_rd_idx !== 5'(i + 1) || wb_rd_data !== 32'h1000 + i + 1)
        begin n_errors++; $display("FAIL ptr_wrap[%0d]: en=%b idx=%0d data=%h want 1/%0d/%h", i, wb_rd_en, wb_rd_idx, wb_rd_data, i + 1, 32'h1000 + i + 1); end
    end
    n_checks++; if (wb_count !== exp_count)
      begin n_errors++; $display("FAIL wrap_count_end: got %0d want %0d", wb_count, exp_count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic xv, xe, lv;
      logic [4:0] xi, li;
      logic [31:0] pm;
      pm = model_mask();
      xv = ($urandom_range(0, 2) != 0);
      xe = ($urandom_range(0, 4) != 0);
      xi = 5'($urandom_range(0, 31));
      if (pm[xi]) xe = 0;
      lv = ($urandom_range(0, 1) != 0);
      li = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      tick(xv, xe, xi, $urandom, lv, li, $urandom);
      n_checks++; if (obs_ready !== exp_ready)
        begin n_errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, obs_ready, exp_ready); end
      n_checks++; if (wb_rd_en !== exp_en)
        begin n_errors++; $display("FAIL rand_en[%0d]: got %b want %b", c, wb_rd_en, exp_en); end
      n_checks++; if (wb_rd_idx !== exp_idx || wb_rd_data !== exp_data)
        begin n_errors++; $display("FAIL rand_wb[%0d]: idx=%0d data=%h want %0d/%h", c, wb_rd_idx, wb_rd_data, exp_idx, exp_data); end
      n_checks++; if (pending_mask !== model_mask())
        begin n_errors++; $display("FAIL rand_mask[%0d]: got %h want %h", c, pending_mask, model_mask()); end
      n_checks++; if (wb_count !== exp_count)
        begin n_errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, wb_count, exp_count); end
    end
  endtask

  initial begin
    test_reset();
    test_execute();
    test_bypass();
    test_contention();
    test_x0();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
